// File: rtl/mem_ctrl.sv
// Purpose: shares one byte-wide RAM port between IF fetches and LSB loads/stores; little-endian assembly.
// Latency: request seen in cycle 0; N-byte read done in cycle N+2, N-byte write done in cycle N+1.
// Backpressure: requesters hold enable until done; rdy=0 freezes all state; IO-full stalls IO writes.
// Ports: clk/rst (async, active low) / rdy global enable;
//        if_to_mc_* / mc_to_if_*   : 4-byte instruction fetch request and result;
//        lsb_to_mc_* / mc_to_lsb_* : 1/2/4-byte load/store request and load result;
//        rob_to_mc_flush           : aborts in-flight reads;
//        mem_din/mem_dout/mem_a/mem_wr, io_buffer_full : RAM/IO bus.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_to_mc_enable,
  input  logic [ADDR_W-1:0] if_to_mc_pc,
  output logic              mc_to_if_done,
  output logic [31:0]       mc_to_if_result,
  input  logic              lsb_to_mc_enable,
  input  logic              lsb_to_mc_wr,
  input  logic [ADDR_W-1:0] lsb_to_mc_addr,
  input  logic [2:0]        lsb_to_mc_len,
  input  logic [31:0]       lsb_to_mc_data,
  output logic              mc_to_lsb_done,
  output logic [31:0]       mc_to_lsb_result,
  input  logic              rob_to_mc_flush,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  typedef enum logic [1:0] {IDLE, IF_READ, LS_READ, LS_WRITE} state_t;

  state_t            state, state_n;
  logic [2:0]        issue_cnt, recv_cnt, len;
  logic [ADDR_W-1:0] base;
  logic [31:0]       wdata, rbuf, rbuf_n;
  logic              if_done_q, lsb_done_q;
  logic              accept_lsb, accept_if, issue, capture, finish;
  logic              pending, io_stall;
  logic [ADDR_W-1:0] cur_addr, prev_addr;

  assign cur_addr  = base + {{(ADDR_W-3){1'b0}}, issue_cnt};
  assign prev_addr = base + {{(ADDR_W-3){1'b0}}, issue_cnt - 3'd1};
  // A byte was addressed last active cycle and its data has not been captured yet.
  assign pending   = (recv_cnt != issue_cnt);
  assign io_stall  = io_buffer_full && (cur_addr[17:16] == 2'b11);

  // Done registers survive a rdy=0 stretch, so the pulse appears once rdy returns.
  assign mc_to_if_done  = if_done_q && rdy;
  assign mc_to_lsb_done = lsb_done_q && rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else if (rdy) begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    accept_lsb = 1'b0;
    accept_if  = 1'b0;
    issue      = 1'b0;
    capture    = 1'b0;
    finish     = 1'b0;
    rbuf_n     = rbuf;
    mem_a      = '0;
    mem_dout   = '0;
    mem_wr     = 1'b0;
    case (state)
      IDLE: begin
        // No accept during a done cycle: the finishing requester still holds enable.
        if (rdy && !rob_to_mc_flush && !if_done_q && !lsb_done_q) begin
          if (lsb_to_mc_enable) begin
            accept_lsb = 1'b1;
            state_n    = lsb_to_mc_wr ? LS_WRITE : LS_READ;
          end else if (if_to_mc_enable) begin
            accept_if = 1'b1;
            state_n   = IF_READ;
          end
        end
      end
      IF_READ, LS_READ: begin
        if (rdy) begin
          if (issue_cnt < len) begin
            mem_a = cur_addr;
            issue = 1'b1;
          end
          if (pending) begin
            capture = 1'b1;
            rbuf_n[{recv_cnt[1:0], 3'b000} +: 8] = mem_din;
            finish  = (recv_cnt + 3'd1 == len) && !rob_to_mc_flush;
          end
          if (rob_to_mc_flush || finish) begin
            state_n = IDLE;
          end
        end else if (pending) begin
          // Keep re-addressing the uncaptured byte so mem_din is still valid when rdy returns.
          mem_a = prev_addr;
        end
      end
      LS_WRITE: begin
        // Flush is ignored here: stores only reach us after commit.
        mem_a    = cur_addr;
        mem_dout = wdata[{issue_cnt[1:0], 3'b000} +: 8];
        if (rdy && !io_stall) begin
          mem_wr = 1'b1;
          issue  = 1'b1;
          if (issue_cnt + 3'd1 == len) begin
            finish  = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_cnt        <= '0;
      recv_cnt         <= '0;
      len              <= '0;
      base             <= '0;
      wdata            <= '0;
      rbuf             <= '0;
      if_done_q        <= 1'b0;
      lsb_done_q       <= 1'b0;
      mc_to_if_result  <= '0;
      mc_to_lsb_result <= '0;
    end else if (rdy) begin
      if_done_q  <= finish && (state == IF_READ);
      lsb_done_q <= finish && (state != IF_READ);
      if (accept_lsb || accept_if) begin
        issue_cnt <= '0;
        recv_cnt  <= '0;
        rbuf      <= '0;   // unread upper lanes stay zero
        base      <= accept_lsb ? lsb_to_mc_addr : if_to_mc_pc;
        len       <= accept_lsb ? lsb_to_mc_len : 3'd4;
        wdata     <= lsb_to_mc_data;
      end else begin
        if (issue) begin
          issue_cnt <= issue_cnt + 3'd1;
        end
        if (capture) begin
          recv_cnt <= recv_cnt + 3'd1;
          rbuf     <= rbuf_n;
        end
      end
      if (finish && state == IF_READ) begin
        mc_to_if_result <= rbuf_n;
      end
      if (finish && state == LS_READ) begin
        mc_to_lsb_result <= rbuf_n;
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Purpose: self-checking bench for mem_ctrl with a synchronous byte RAM model and result scoreboards.
// Latency: each scenario runs a fixed cycle window counted from the cycle its request is driven.
// Backpressure: exercises rdy=0 stretches, IO-full stalls, flush and arbitration between requesters.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        if_to_mc_enable;
  logic [31:0] if_to_mc_pc;
  logic        mc_to_if_done;
  logic [31:0] mc_to_if_result;
  logic        lsb_to_mc_enable, lsb_to_mc_wr;
  logic [31:0] lsb_to_mc_addr;
  logic [2:0]  lsb_to_mc_len;
  logic [31:0] lsb_to_mc_data;
  logic        mc_to_lsb_done;
  logic [31:0] mc_to_lsb_result;
  logic        rob_to_mc_flush;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;

  logic [7:0]  ram [0:262143];
  logic        pl_we;
  logic [17:0] pl_a;
  logic [7:0]  pl_d;

  int errors = 0;
  int checks = 0;
  logic [31:0] if_q[$];
  logic [31:0] lsb_q[$];
  logic [31:0] st_q[$];

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_to_mc_enable(if_to_mc_enable), .if_to_mc_pc(if_to_mc_pc),
    .mc_to_if_done(mc_to_if_done), .mc_to_if_result(mc_to_if_result),
    .lsb_to_mc_enable(lsb_to_mc_enable), .lsb_to_mc_wr(lsb_to_mc_wr),
    .lsb_to_mc_addr(lsb_to_mc_addr), .lsb_to_mc_len(lsb_to_mc_len),
    .lsb_to_mc_data(lsb_to_mc_data), .mc_to_lsb_done(mc_to_lsb_done),
    .mc_to_lsb_result(mc_to_lsb_result), .rob_to_mc_flush(rob_to_mc_flush),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: data for the address of cycle k appears in cycle k+1.
  always @(posedge clk) begin
    mem_din <= ram[mem_a[17:0]];
    if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
    if (pl_we) ram[pl_a] <= pl_d;
  end

  task automatic poke(input logic [17:0] a, input logic [7:0] d);
    pl_we = 1'b1; pl_a = a; pl_d = d;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    checks++;
    if (mem_a !== 32'h0 || mem_wr !== 1'b0 || mem_dout !== 8'h0) begin
      errors++; $display("FAIL reset_bus: got a=%h wr=%b dout=%h, want 0/0/0", mem_a, mem_wr, mem_dout);
    end
    checks++;
    if (mc_to_if_done !== 1'b0 || mc_to_lsb_done !== 1'b0) begin
      errors++; $display("FAIL reset_done: got %b %b, want 0 0", mc_to_if_done, mc_to_lsb_done);
    end
    checks++;
    if (mc_to_if_result !== 32'h0 || mc_to_lsb_result !== 32'h0) begin
      errors++; $display("FAIL reset_result: got %h %h, want 0 0", mc_to_if_result, mc_to_lsb_result);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (mem_a !== 32'h0 || mem_wr !== 1'b0) begin
      errors++; $display("FAIL reset_idle_bus: got a=%h wr=%b, want 0/0", mem_a, mem_wr);
    end
  endtask

  task automatic test_if_fetch();
    logic [31:0] exp_v;
    poke(18'h100, 8'h13); poke(18'h101, 8'h05); poke(18'h102, 8'h50); poke(18'h103, 8'h00);
    for (int c = 0; c < 9; c++) begin
      if (c == 0) begin if_to_mc_enable = 1'b1; if_to_mc_pc = 32'h100; if_q.push_back(32'h0050_0513); end
      if (c == 7) if_to_mc_enable = 1'b0;
      @(negedge clk);
      checks++;
      if (mc_to_if_done !== (c == 6)) begin
        errors++; $display("FAIL if_fetch_done c=%0d: got %b, want %b", c, mc_to_if_done, c == 6);
      end
      if (c >= 1 && c <= 4) begin
        checks++;
        if (mem_a !== 32'h100 + 32'(c) - 32'd1 || mem_wr !== 1'b0) begin
          errors++; $display("FAIL if_fetch_addr c=%0d: got a=%h wr=%b, want %h/0", c, mem_a, mem_wr, 32'h100 + 32'(c) - 32'd1);
        end
      end
      if (mc_to_if_done === 1'b1 && if_q.size() != 0) begin
        exp_v = if_q.pop_front();
        checks++;
        if (mc_to_if_result !== exp_v) begin
          errors++; $display("FAIL if_fetch_result: got %h, want %h", mc_to_if_result, exp_v);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (if_q.size() != 0) begin
      errors++; $display("FAIL if_fetch_timeout: got %0d outstanding, want 0", if_q.size()); if_q.delete();
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] exp_v;
    poke(18'h2000, 8'h34); poke(18'h2001, 8'h12);
    poke(18'h0, 8'h93); poke(18'h1, 8'h00); poke(18'h2, 8'h10); poke(18'h3, 8'h00);
    for (int c = 0; c < 14; c++) begin
      if (c == 0) begin
        if_to_mc_enable = 1'b1; if_to_mc_pc = 32'h0;
        lsb_to_mc_enable = 1'b1; lsb_to_mc_wr = 1'b0; lsb_to_mc_addr = 32'h2000; lsb_to_mc_len = 3'd2;
        lsb_q.push_back(32'h0000_1234); if_q.push_back(32'h0010_0093);
      end
      if (c == 5) lsb_to_mc_enable = 1'b0;
      if (c == 12) if_to_mc_enable = 1'b0;
      @(negedge clk);
      checks++;
      if (mc_to_lsb_done !== (c == 4) || mc_to_if_done !== (c == 11)) begin
        errors++; $display("FAIL simul_done c=%0d: got lsb=%b if=%b, want %b %b", c, mc_to_lsb_done, mc_to_if_done, c == 4, c == 11);
      end
      if (c == 1 || c == 2 || (c >= 6 && c <= 9)) begin
        exp_v = (c <= 2) ? 32'h2000 + 32'(c) - 32'd1 : 32'(c) - 32'd6;
        checks++;
        if (mem_a !== exp_v) begin
          errors++; $display("FAIL simul_addr c=%0d: got %h, want %h", c, mem_a, exp_v);
        end
      end
      if (mc_to_lsb_done === 1'b1 && lsb_q.size() != 0) begin
        exp_v = lsb_q.pop_front();
        checks++;
        if (mc_to_lsb_result !== exp_v) begin
          errors++; $display("FAIL simul_lsb_result: got %h, want %h", mc_to_lsb_result, exp_v);
        end
      end
      if (mc_to_if_done === 1'b1 && if_q.size() != 0) begin
        exp_v = if_q.pop_front();
        checks++;
        if (mc_to_if_result !== exp_v) begin
          errors++; $display("FAIL simul_if_result: got %h, want %h", mc_to_if_result, exp_v);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (if_q.size() != 0 || lsb_q.size() != 0) begin
      errors++; $display("FAIL simul_timeout: got %0d/%0d outstanding, want 0", if_q.size(), lsb_q.size());
      if_q.delete(); lsb_q.delete();
    end
  endtask

  task automatic test_store();
    logic [31:0] d, exp_v;
    d = 32'hDEAD_BEEF;
    poke(18'h1000, 8'h0); poke(18'h1001, 8'h0); poke(18'h1002, 8'h0); poke(18'h1003, 8'h0);
    for (int c = 0; c < 8; c++) begin
      if (c == 0) begin
        lsb_to_mc_enable = 1'b1; lsb_to_mc_wr = 1'b1; lsb_to_mc_addr = 32'h1000;
        lsb_to_mc_len = 3'd4; lsb_to_mc_data = d; st_q.push_back(d);
      end
      if (c == 6) begin lsb_to_mc_enable = 1'b0; lsb_to_mc_wr = 1'b0; end
      @(negedge clk);
      checks++;
      if (mc_to_lsb_done !== (c == 5)) begin
        errors++; $display("FAIL store_done c=%0d: got %b, want %b", c, mc_to_lsb_done, c == 5);
      end
      checks++;
      if (c >= 1 && c <= 4) begin
        if (mem_wr !== 1'b1 || mem_a !== 32'h1000 + 32'(c) - 32'd1 || mem_dout !== d[8*(c-1) +: 8]) begin
          errors++; $display("FAIL store_bus c=%0d: got wr=%b a=%h dout=%h, want 1/%h/%h", c, mem_wr, mem_a, mem_dout, 32'h1000 + 32'(c) - 32'd1, d[8*(c-1) +: 8]);
        end
      end else if (mem_wr !== 1'b0) begin
        errors++; $display("FAIL store_wr_idle c=%0d: got %b, want 0", c, mem_wr);
      end
      if (mc_to_lsb_done === 1'b1 && st_q.size() != 0) begin
        exp_v = st_q.pop_front();
        checks++;
        if ({ram[18'h1003], ram[18'h1002], ram[18'h1001], ram[18'h1000]} !== exp_v) begin
          errors++; $display("FAIL store_ram: got %h, want %h", {ram[18'h1003], ram[18'h1002], ram[18'h1001], ram[18'h1000]}, exp_v);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (st_q.size() != 0) begin
      errors++; $display("FAIL store_timeout: got %0d outstanding, want 0", st_q.size()); st_q.delete();
    end
  endtask

  task automatic test_lw_rdy();
    logic [31:0] exp_v;
    for (int c = 0; c < 11; c++) begin
      if (c == 0) begin
        lsb_to_mc_enable = 1'b1; lsb_to_mc_wr = 1'b0; lsb_to_mc_addr = 32'h1000;
        lsb_to_mc_len = 3'd4; lsb_q.push_back(32'hDEAD_BEEF);
      end
      if (c == 2) rdy = 1'b0;
      if (c == 4) rdy = 1'b1;
      if (c == 9) lsb_to_mc_enable = 1'b0;
      @(negedge clk);
      checks++;
      if (mc_to_lsb_done !== (c == 8) || mem_wr !== 1'b0) begin
        errors++; $display("FAIL lw_rdy_done c=%0d: got done=%b wr=%b, want %b/0", c, mc_to_lsb_done, mem_wr, c == 8);
      end
      if (mc_to_lsb_done === 1'b1 && lsb_q.size() != 0) begin
        exp_v = lsb_q.pop_front();
        checks++;
        if (mc_to_lsb_result !== exp_v) begin
          errors++; $display("FAIL lw_rdy_result: got %h, want %h", mc_to_lsb_result, exp_v);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (lsb_q.size() != 0) begin
      errors++; $display("FAIL lw_rdy_timeout: got %0d outstanding, want 0", lsb_q.size()); lsb_q.delete();
    end
  endtask

  task automatic test_rdy_done();
    logic [31:0] exp_v;
    for (int c = 0; c < 7; c++) begin
      if (c == 0) begin
        lsb_to_mc_enable = 1'b1; lsb_to_mc_wr = 1'b0; lsb_to_mc_addr = 32'h2001;
        lsb_to_mc_len = 3'd1; lsb_q.push_back(32'h0000_0012);
      end
      if (c == 3) rdy = 1'b0;
      if (c == 4) rdy = 1'b1;
      if (c == 5) lsb_to_mc_enable = 1'b0;
      @(negedge clk);
      checks++;
      if (mc_to_lsb_done !== (c == 4)) begin
        errors++; $display("FAIL rdy_done_pulse c=%0d: got %b, want %b", c, mc_to_lsb_done, c == 4);
      end
      if (mc_to_lsb_done === 1'b1 && lsb_q.size() != 0) begin
        exp_v = lsb_q.pop_front();
        checks++;
        if (mc_to_lsb_result !== exp_v) begin
          errors++; $display("FAIL rdy_done_result: got %h, want %h", mc_to_lsb_result, exp_v);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (lsb_q.size() != 0) begin
      errors++; $display("FAIL rdy_done_timeout: got %0d outstanding, want 0", lsb_q.size()); lsb_q.delete();
    end
  endtask

  task automatic test_io_stall();
    logic [31:0] exp_v;
    poke(18'h30000, 8'h00);
    for (int c = 0; c < 8; c++) begin
      if (c == 0) begin
        lsb_to_mc_enable = 1'b1; lsb_to_mc_wr = 1'b1; lsb_to_mc_addr = 32'h3_0000;
        lsb_to_mc_len = 3'd1; lsb_to_mc_data = 32'h1234_565A; st_q.push_back(32'h0000_005A);
      end
      if (c == 1) io_buffer_full = 1'b1;
      if (c == 4) io_buffer_full = 1'b0;
      if (c == 6) begin lsb_to_mc_enable = 1'b0; lsb_to_mc_wr = 1'b0; end
      @(negedge clk);
      checks++;
      if (mc_to_lsb_done !== (c == 5)) begin
        errors++; $display("FAIL io_stall_done c=%0d: got %b, want %b", c, mc_to_lsb_done, c == 5);
      end
      checks++;
      if (c == 4) begin
        if (mem_wr !== 1'b1 || mem_a !== 32'h3_0000 || mem_dout !== 8'h5A) begin
          errors++; $display("FAIL io_stall_write: got wr=%b a=%h dout=%h, want 1/00030000/5a", mem_wr, mem_a, mem_dout);
        end
      end else if (mem_wr !== 1'b0) begin
        errors++; $display("FAIL io_stall_wr c=%0d: got %b, want 0", c, mem_wr);
      end
      if (mc_to_lsb_done === 1'b1 && st_q.size() != 0) begin
        exp_v = st_q.pop_front();
        checks++;
        if ({24'h0, ram[18'h30000]} !== exp_v) begin
          errors++; $display("FAIL io_stall_ram: got %h, want %h", ram[18'h30000], exp_v);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (st_q.size() != 0) begin
      errors++; $display("FAIL io_stall_timeout: got %0d outstanding, want 0", st_q.size()); st_q.delete();
    end
  endtask

  task automatic test_flush();
    logic [31:0] exp_v;
    poke(18'h200, 8'h37); poke(18'h201, 8'h01); poke(18'h202, 8'h02); poke(18'h203, 8'h00);
    for (int c = 0; c < 12; c++) begin
      if (c == 0) begin if_to_mc_enable = 1'b1; if_to_mc_pc = 32'h100; end
      if (c == 3) rob_to_mc_flush = 1'b1;
      if (c == 4) begin rob_to_mc_flush = 1'b0; if_to_mc_pc = 32'h200; if_q.push_back(32'h0002_0137); end
      if (c == 11) if_to_mc_enable = 1'b0;
      @(negedge clk);
      checks++;
      if (mc_to_if_done !== (c == 10)) begin
        errors++; $display("FAIL flush_done c=%0d: got %b, want %b", c, mc_to_if_done, c == 10);
      end
      if (c == 4 || c == 5) begin
        exp_v = (c == 4) ? 32'h0 : 32'h200;
        checks++;
        if (mem_a !== exp_v) begin
          errors++; $display("FAIL flush_addr c=%0d: got %h, want %h", c, mem_a, exp_v);
        end
      end
      if (mc_to_if_done === 1'b1 && if_q.size() != 0) begin
        exp_v = if_q.pop_front();
        checks++;
        if (mc_to_if_result !== exp_v) begin
          errors++; $display("FAIL flush_result: got %h, want %h", mc_to_if_result, exp_v);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (if_q.size() != 0) begin
      errors++; $display("FAIL flush_timeout: got %0d outstanding, want 0", if_q.size()); if_q.delete();
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_v;
    poke(18'h3FFFF, 8'h77); poke(18'h0, 8'h93);
    for (int c = 0; c < 7; c++) begin
      if (c == 0) begin
        lsb_to_mc_enable = 1'b1; lsb_to_mc_wr = 1'b0; lsb_to_mc_addr = 32'hFFFF_FFFF;
        lsb_to_mc_len = 3'd2; lsb_q.push_back(32'h0000_9377);
      end
      if (c == 5) lsb_to_mc_enable = 1'b0;
      @(negedge clk);
      checks++;
      if (mc_to_lsb_done !== (c == 4)) begin
        errors++; $display("FAIL wrap_done c=%0d: got %b, want %b", c, mc_to_lsb_done, c == 4);
      end
      if (c == 1 || c == 2) begin
        exp_v = (c == 1) ? 32'hFFFF_FFFF : 32'h0;
        checks++;
        if (mem_a !== exp_v) begin
          errors++; $display("FAIL wrap_addr c=%0d: got %h, want %h", c, mem_a, exp_v);
        end
      end
      if (mc_to_lsb_done === 1'b1 && lsb_q.size() != 0) begin
        exp_v = lsb_q.pop_front();
        checks++;
        if (mc_to_lsb_result !== exp_v) begin
          errors++; $display("FAIL wrap_result: got %h, want %h", mc_to_lsb_result, exp_v);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (lsb_q.size() != 0) begin
      errors++; $display("FAIL wrap_timeout: got %0d outstanding, want 0", lsb_q.size()); lsb_q.delete();
    end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 5; c++) begin
      if (c == 0) begin
        lsb_to_mc_enable = 1'b1; lsb_to_mc_wr = 1'b1; lsb_to_mc_addr = 32'h1100;
        lsb_to_mc_len = 3'd4; lsb_to_mc_data = 32'hCAFE_F00D;
      end
      @(negedge clk);
      if (c == 2) begin
        checks++;
        if (mem_wr !== 1'b1) begin
          errors++; $display("FAIL arst_prewrite: got wr=%b, want 1", mem_wr);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (mem_wr !== 1'b0 || mem_a !== 32'h0 || mem_dout !== 8'h0) begin
          errors++; $display("FAIL arst_bus: got wr=%b a=%h dout=%h, want 0/0/0", mem_wr, mem_a, mem_dout);
        end
        checks++;
        if (mc_to_if_result !== 32'h0 || mc_to_lsb_result !== 32'h0 || mc_to_lsb_done !== 1'b0) begin
          errors++; $display("FAIL arst_regs: got if=%h lsb=%h done=%b, want 0/0/0", mc_to_if_result, mc_to_lsb_result, mc_to_lsb_done);
        end
        #1 rst = 1'b1;
        lsb_to_mc_enable = 1'b0; lsb_to_mc_wr = 1'b0;
      end
      if (c == 3) begin
        checks++;
        if (mem_wr !== 1'b0 || mem_a !== 32'h0) begin
          errors++; $display("FAIL arst_idle: got wr=%b a=%h, want 0/0", mem_wr, mem_a);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rdy = 1'b1; rst = 1'b1; pl_we = 1'b0; pl_a = '0; pl_d = '0;
    if_to_mc_enable = 1'b0; if_to_mc_pc = '0;
    lsb_to_mc_enable = 1'b0; lsb_to_mc_wr = 1'b0; lsb_to_mc_addr = '0;
    lsb_to_mc_len = 3'd0; lsb_to_mc_data = '0;
    rob_to_mc_flush = 1'b0; io_buffer_full = 1'b0;
    test_reset();
    test_if_fetch();
    test_simultaneous();
    test_store();
    test_lw_rdy();
    test_rdy_done();
    test_io_stall();
    test_flush();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller that shares the single byte-wide RAM port between the instruction fetcher (4-byte fetches on icache miss) and the load/store buffer (1/2/4-byte loads and stores). It arbitrates pending requests and sequences each one as a run of byte accesses on the RAM bus. It assembles little-endian read results and returns them with a one-cycle done pulse. It sits between the iFetch/LSB units and the top-level RAM/IO interface.

## Interface
- `ADDR_W`, default 32, address width.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `rdy`  in  1  global enable; when low, all state freezes.
- `if_to_mc_enable`  in  1  fetch request; held until done.
- `if_to_mc_pc`  in  32  fetch byte address.
- `mc_to_if_done`  out  1  one-cycle pulse; fetch result valid.
- `mc_to_if_result`  out  32  fetched instruction.
- `lsb_to_mc_enable`  in  1  load/store request; held until done.
- `lsb_to_mc_wr`  in  1  1 = store, 0 = load.
- `lsb_to_mc_addr`  in  32  byte address.
- `lsb_to_mc_len`  in  3  byte count; legal values are 1, 2 and 4.
- `lsb_to_mc_data`  in  32  store data; low `len` bytes are used.
- `mc_to_lsb_done`  out  1  one-cycle pulse.
- `mc_to_lsb_result`  out  32  load data, zero-extended raw bytes.
- `rob_to_mc_flush`  in  1  misprediction flush.
- `mem_din`  in  8  RAM read byte.
- `mem_dout`  out  8  RAM write byte.
- `mem_a`  out  32  RAM address.
- `mem_wr`  out  1  1 = write.
- `io_buffer_full`  in  1  IO write buffer full.

## Operation
- States: IDLE, IF_READ, LS_READ, LS_WRITE.
- Per-access counters:
  - 3-bit `issue_cnt` counts bytes addressed.
  - 3-bit `recv_cnt` counts bytes captured.
  - `len` is latched at accept (4 for fetch).
- IDLE arbitration is fixed priority: LSB over IF.
  - A requester whose done is high in the current cycle is ignored, so a held enable is not re-accepted.
  - The address and store data are latched at accept.
- IF_READ / LS_READ:
  - Each cycle: `mem_a` = base + `issue_cnt`, `mem_wr` = 0, while `issue_cnt` < `len`.
  - `mem_din` is captured one cycle after its address, into byte lane `recv_cnt`.
  - When `recv_cnt` reaches `len`: result registered, done pulsed, return to IDLE.
- LS_WRITE:
  - Each cycle: `mem_a` = base + `issue_cnt`, `mem_dout` = data byte `issue_cnt`, `mem_wr` = 1.
  - After `len` bytes: done pulsed, return to IDLE.
- IO stall: when `io_buffer_full` = 1 and the write address has `[17:16]` = 2'b11, no byte is issued that cycle (`mem_wr` = 0) and the counters hold.
- Flush:
  - In IF_READ or LS_READ, `rob_to_mc_flush` = 1 returns the block to IDLE at the next edge. No done, no result update.
  - In LS_WRITE, flush is ignored and the store completes, because stores are only issued after commit.
  - In IDLE, a flush suppresses acceptance that cycle.
- `rdy` = 0:
  - State, counters and result registers hold.
  - `mem_wr` is forced to 0, so no duplicate IO writes occur.
  - done outputs are forced to 0, and a pending pulse is re-emitted once `rdy` returns.
- Bytes not read (len < 4) are 0 in the result.

## Timing
- Reset (async, `rst` = 0) values:
  - state = IDLE
  - `mem_a` = 0, `mem_dout` = 0, `mem_wr` = 0
  - both done = 0, both results = 0
  - counters = 0
- Request sampled in cycle 0 (IDLE): first address is on `mem_a` in cycle 1.
- Read of N bytes:
  - Addresses in cycles 1..N.
  - Bytes captured at the end of cycles 2..N+1.
  - done high in cycle N+2, so a fetch takes 6 cycles and LB takes 3.
- Write of N bytes: writes in cycles 1..N, done high in cycle N+1.
- Requester deasserts enable at the edge ending its done cycle. The earliest next accept is in the cycle after done.
- Idle bus: `mem_a` = 0, `mem_wr` = 0.
- Address arithmetic wraps modulo 2^32.

## Test plan
- IF fetch: pc = 0x100, RAM[0x100..0x103] = 13 05 50 00.
  - `mem_a` = 0x100..0x103 in cycles 1..4.
  - `mc_to_if_done` is high only in cycle 6, with result = 0x00500513.
- Simultaneous requests: IF (pc 0x0) and LSB load (len 2, addr 0x2000) in the same cycle.
  - LSB is served first, done in cycle 4.
  - IF is accepted in cycle 5, with done in cycle 11.
- Store SW: data 0xDEADBEEF to 0x1000.
  - `mem_wr` = 1 in cycles 1..4 with `mem_dout` = EF, BE, AD, DE.
  - `mc_to_lsb_done` high in cycle 5.
- IO stall: SB to 0x30000 with `io_buffer_full` = 1 for cycles 1–3.
  - `mem_wr` = 0 in cycles 1–3, write issued in cycle 4, done in cycle 5.
- Flush mid-fetch: flush asserted in cycle 3.
  - IDLE in cycle 4, no `mc_to_if_done`.
  - A new fetch request in cycle 4 is accepted and its result is correct.
- Reset and `rdy`:
  - Async `rst` low mid-write: all outputs go to 0 immediately.
  - `rdy` low for 2 cycles during an LW: the completion is delayed by 2 cycles and the result is unchanged.
